descrambler_16bit: RTL
======================

DESCRAMBLER_16BIT -- requirements
Module: descrambler_16bit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 seed_load  input  1  load seed into keystream LFSR this cycle.
REQ-005 seed  input  16  LFSR seed value.
REQ-006 in_valid  input  1  in_data/in_par present.
REQ-007 in_data  input  16  scrambled word.
REQ-008 in_par  input  1  even-parity bit over in_data (used only with DESCRAMBLE_PARITY_EN).
REQ-009 in_ready  output  1  block can accept a word this cycle.
REQ-010 out_valid  output  1  out_data holds a descrambled word.
REQ-011 out_data  output  16  descrambled word.
REQ-012 out_perr  output  1  parity error flag for the word in out_data.
REQ-013 out_ready  input  1  consumer takes out_data this cycle.
REQ-014 word_cnt  output  16  count of words accepted since reset or seed load.

Function
REQ-015 LFSR SHALL be 16 bits, polynomial x^16+x^14+x^13+x^11+1; step: next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
REQ-016 Keystream for a word SHALL be the current LFSR state; out_data <= in_data XOR lfsr on acceptance.
REQ-017 Acceptance SHALL occur when in_valid && in_ready && !seed_load; LFSR steps exactly once per accepted word, never otherwise.
REQ-018 in_ready SHALL equal (!out_valid || out_ready) && !seed_load (single output register, combinational ready).
REQ-019 Latency SHALL be 1 cycle: word accepted at edge N is visible on out_data with out_valid=1 after edge N.
REQ-020 out_valid SHALL clear when out_ready=1 and no new word is accepted the same cycle; simultaneous drain and accept SHALL keep out_valid=1 with new data.
REQ-021 out_data and out_perr SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 seed_load SHALL have priority over everything: lfsr <= seed (seed==0 substitutes 16'hACE1 to avoid lock-up), out_valid <= 0, word_cnt <= 0, no word accepted.
REQ-023 word_cnt SHALL increment by 1 per accepted word, wrapping 16'hFFFF -> 16'h0000.

Reset
REQ-024 On rst: lfsr=16'hACE1, out_valid=0, out_data=16'h0000, out_perr=0, word_cnt=0; in_ready=1 after reset released.
REQ-025 rst asserted mid-transfer SHALL discard any held word immediately (asynchronous), with no output glitch to out_valid=1.

Configuration
REQ-026 With macro DESCRAMBLE_PARITY_EN defined, out_perr SHALL register (^in_data ^ in_par) on each accepted word (1 = error).
REQ-027 Without DESCRAMBLE_PARITY_EN, ports SHALL still exist, in_par SHALL be ignored and out_perr SHALL be constant 0.

Verification
REQ-028 Reset, then in_data=16'h0000 accepted twice -> out_data 16'hACE1 then 16'h59C3, word_cnt=2.
REQ-029 seed_load with seed=16'h0001, then in_data=16'h1234 -> out_data=16'h1235; seed=16'h0000 load then in_data=0 -> out_data=16'hACE1.
REQ-030 out_ready=0, two words offered back-to-back -> first held stable, in_ready=0, second stalled; LFSR stepped once; releasing out_ready delivers second with next keystream.
REQ-031 seed_load asserted while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, word not accepted, word_cnt=0.
REQ-032 DESCRAMBLE_PARITY_EN defined, in_data=16'h0001, in_par=0 -> out_perr=1; in_par=1 -> out_perr=0; macro undefined -> out_perr=0 in both cases.
REQ-033 rst pulsed while out_valid=1 -> out_valid=0 immediately, lfsr=16'hACE1, word_cnt=0.

Source files
------------

// File: rtl/descrambler_16bit.sv
// 16-bit additive descrambler: keystream LFSR x^16+x^14+x^13+x^11+1, one-word output register.
// Optional parity checking enabled by defining DESCRAMBLE_PARITY_EN.
module descrambler_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic [15:0] seed,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_par,
    output logic        in_ready,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_perr,
    input  logic        out_ready,
    output logic [15:0] word_cnt
);

    localparam logic [15:0] LFSR_INIT = 16'hACE1;

    logic [15:0] lfsr_q,      lfsr_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_data_q,  out_data_d;
    logic [15:0] word_cnt_q,  word_cnt_d;
    logic        accept;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // The output register may be refilled in the same cycle it drains.
    assign in_ready = (!out_valid_q || out_ready) && !seed_load;
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        lfsr_d      = lfsr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        word_cnt_d  = word_cnt_q;

        if (seed_load) begin
            // An all-zero seed would lock the LFSR; fall back to the reset value.
            lfsr_d      = (seed == 16'h0000) ? LFSR_INIT : seed;
            out_valid_d = 1'b0;
            word_cnt_d  = 16'h0000;
        end else if (accept) begin
            lfsr_d      = lfsr_step(lfsr_q);
            out_valid_d = 1'b1;
            out_data_d  = in_data ^ lfsr_q;
            word_cnt_d  = word_cnt_q + 16'h0001;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q      <= LFSR_INIT;
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
            word_cnt_q  <= 16'h0000;
        end else begin
            lfsr_q      <= lfsr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

`ifdef DESCRAMBLE_PARITY_EN
    logic out_perr_q, out_perr_d;

    always_comb begin
        out_perr_d = out_perr_q;
        if (!seed_load && accept) begin
            out_perr_d = (^in_data) ^ in_par;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_perr_q <= 1'b0;
        end else begin
            out_perr_q <= out_perr_d;
        end
    end

    assign out_perr = out_perr_q;
`else
    logic unused_par;
    assign unused_par = in_par;
    assign out_perr   = 1'b0;
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign word_cnt  = word_cnt_q;

endmodule
